fetch_wave_streamer: RTL and testbench
======================================

Name: fetch_wave_streamer

Overview:
- Fetch-side producer of the instruction-buffer interface that the wavepool consumes (buff_tag / buff_instr / buff2fetchwave_ack).
- Holds a PC per wavefront slot and round-robin picks an eligible slot, then issues an instruction-memory read and a queue-slot reservation.
- Forwards the returned instruction word with its tag to the wavepool.
- Honours wavepool back-pressure (fetch_stop_fetch), SALU branch redirects, wavefront completion, and new-wavefront dispatch, including base-register write-through.

Parameters:
NUM_WF, 40, number of wavefront slots
WFID_W, 6, wavefront id width
PC_W, 32, PC / instruction width
PC_INCR, 4, PC advance per fetched dword

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (asserted at 0)
dispatch_valid  in  1  new wavefront dispatch pulse
dispatch_wfid  in  6  slot of new wavefront
dispatch_pc  in  32  start PC
dispatch_vgpr_base  in  10  VGPR base
dispatch_sgpr_base  in  9  SGPR base
dispatch_lds_base  in  16  LDS base
fetch_basereg_wr  out  1  base-register write strobe
fetch_basereg_wfid  out  6  base-register write slot
fetch_vgpr_base  out  10  registered VGPR base
fetch_sgpr_base  out  9  registered SGPR base
fetch_lds_base  out  16  registered LDS base
fetch_stop_fetch  in  40  per-slot wavepool queue-full back-pressure
issue_wf_done_en  in  1  wavefront finished
issue_wf_done_wf_id  in  6  finished slot
salu_branch_en  in  1  branch resolved
salu_branch_wfid  in  6  branching slot
salu_branch_taken  in  1  branch taken
salu_branch_target  in  32  taken target PC
mem_rd_ready  in  1  instruction memory can accept a request
mem_rd_en  out  1  read request
mem_rd_addr  out  32  read PC
mem_rd_tag  out  6  request wfid
mem_ack  in  1  response valid
mem_ack_tag  in  6  response wfid
mem_rd_data  in  32  instruction word
fetch_reserve_valid  out  1  wavepool queue-slot reservation
fetch_reserve_slotid  out  6  reserved slot
buff2fetchwave_ack  out  1  instruction valid to wavepool
buff_tag  out  39  {first[38], wfid[37:32], pc[31:0]}
buff_instr  out  32  instruction word

Behaviour:
- Reset (rst=0, async): all outputs 0; active, pending, stale and first vectors cleared; PCs 0; round-robin pointer 0.
- Dispatch: at clock with dispatch_valid=1, set pc[wfid]=dispatch_pc, active=1, first=1, pending=0, stale=0. Next cycle: fetch_basereg_wr=1 with registered wfid and bases, single-cycle pulse.
- Eligibility: eligible[i] = active & ~pending & ~fetch_stop_fetch[i], evaluated on registered state.
- Arbitration: when mem_rd_ready=1 and any slot is eligible, pick the first eligible slot at or after the pointer, wrapping at NUM_WF-1 → 0. Then:
  - pointer = pick+1, wrapping 39 → 0;
  - pending[pick]=1;
  - next cycle: mem_rd_en=1, mem_rd_addr=pc, mem_rd_tag=pick, fetch_reserve_valid=1, fetch_reserve_slotid=pick, all single-cycle;
  - pc[pick] += PC_INCR, mod 2^32.
- Issue rate: at most one issue per cycle. No issue while mem_rd_ready=0.
- Response: mem_ack=1 with tag t:
  - if stale[t]=0 and active[t]=1: next cycle buff2fetchwave_ack=1, buff_tag={first[t], t, request PC}, buff_instr=mem_rd_data; clear first[t].
  - if stale[t]=1 or active[t]=0: discard; no ack.
  - Either case: pending[t]=0, stale[t]=0.
- Request PC: stored per slot at issue (reqpc array) for the response tag.
- Branch taken: pc[wfid]=salu_branch_target; if pending[wfid] then stale[wfid]=1. Not-taken: no state change.
- Done: active=0; an in-flight response is later discarded.
- Simultaneous events, same slot, same cycle:
  - branch taken + issue: target wins the PC, and the issued request is marked stale;
  - branch + response: the response is discarded;
  - done + response: the response is discarded;
  - dispatch + done: dispatch wins;
  - dispatch + response to the same slot: the response is discarded.
- Response and issue in the same cycle are independent and both proceed.

Decomposition:
- Shared package: NUM_WF, WFID_W, PC_W, PC_INCR, and the buff_tag field positions (FIRST_BIT=38, WFID_MSB=37, WFID_LSB=32).
- One sub-module: fetch_rr_arbiter. Inputs: 40-bit eligible vector and pointer. Outputs: grant id and grant valid.

Test Plan:
- Dispatch wf 3 at PC 0x100, mem always ready, 1-cycle memory → mem_rd_addr 0x100/0x104/0x108 on successive requests; first ack buff_tag[38]=1 with pc 0x100; later acks have first=0.
- Dispatch wf 0, 1, 39 → grants rotate 0,1,39,0; wrap 39→0 verified; fetch_reserve_slotid matches each mem_rd_tag.
- fetch_stop_fetch[1]=1 → wf 1 never issued while asserted; resumes the cycle after deassert.
- Branch taken wf 2 to 0x400 while its request is pending → response dropped (no buff2fetchwave_ack); next request has addr 0x400.
- issue_wf_done_en for wf 5 with a pending request → response dropped; wf 5 not issued again until re-dispatched.
- Assert rst=0 mid-stream → all outputs 0 asynchronously; after release, no requests issue until a dispatch arrives.

Source files
------------

// File: rtl/fetch_wave_streamer_pkg.sv
`default_nettype none
// fetch_wave_streamer_pkg: shared sizes, buff_tag field positions and slot-id wrap helper.
// Rev 1.0
package fetch_wave_streamer_pkg;
   localparam int NUM_WF    = 40;
   localparam int WFID_W    = 6;
   localparam int PC_W      = 32;
   localparam int PC_INCR   = 4;
   localparam int FIRST_BIT = 38;
   localparam int WFID_MSB  = 37;
   localparam int WFID_LSB  = 32;
   localparam int TAG_W     = FIRST_BIT + 1;

   typedef logic [WFID_W-1:0] wfid_t;
   typedef logic [PC_W-1:0]   pc_t;

   // Slot-id addition modulo NUM_WF; both operands are assumed already below NUM_WF.
   function automatic wfid_t wfid_wrap_add(input wfid_t base, input wfid_t off);
      logic [WFID_W:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= (WFID_W+1)'(NUM_WF)) s = s - (WFID_W+1)'(NUM_WF);
      return s[WFID_W-1:0];
   endfunction
endpackage
`default_nettype wire

// File: rtl/fetch_wave_streamer_arbiter.sv
`default_nettype none
// fetch_rr_arbiter: picks the first eligible slot at or after the pointer, wrapping past NUM_WF-1.
// Rev 1.0
module fetch_rr_arbiter
   import fetch_wave_streamer_pkg::*;
(
   input  logic [NUM_WF-1:0] i_eligible,
   input  wfid_t             i_ptr,
   output wfid_t             o_grant_id,
   output logic              o_grant_valid
);
   wfid_t w_idx;

   always_comb begin
      o_grant_id    = '0;
      o_grant_valid = 1'b0;
      w_idx         = '0;
      for (int k = 0; k < NUM_WF; k++) begin
         w_idx = wfid_wrap_add(i_ptr, WFID_W'(k));
         if (!o_grant_valid && i_eligible[w_idx]) begin
            o_grant_valid = 1'b1;
            o_grant_id    = w_idx;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/fetch_wave_streamer.sv
`default_nettype none
// fetch_wave_streamer: per-wavefront PC tracking, round-robin instruction fetch and wavepool delivery.
// Rev 1.0
module fetch_wave_streamer
   import fetch_wave_streamer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_dispatch_valid,
   input  wfid_t             i_dispatch_wfid,
   input  pc_t               i_dispatch_pc,
   input  logic [9:0]        i_dispatch_vgpr_base,
   input  logic [8:0]        i_dispatch_sgpr_base,
   input  logic [15:0]       i_dispatch_lds_base,
   output logic              o_fetch_basereg_wr,
   output wfid_t             o_fetch_basereg_wfid,
   output logic [9:0]        o_fetch_vgpr_base,
   output logic [8:0]        o_fetch_sgpr_base,
   output logic [15:0]       o_fetch_lds_base,
   input  logic [NUM_WF-1:0] i_fetch_stop_fetch,
   input  logic              i_issue_wf_done_en,
   input  wfid_t             i_issue_wf_done_wf_id,
   input  logic              i_salu_branch_en,
   input  wfid_t             i_salu_branch_wfid,
   input  logic              i_salu_branch_taken,
   input  pc_t               i_salu_branch_target,
   input  logic              i_mem_rd_ready,
   output logic              o_mem_rd_en,
   output pc_t               o_mem_rd_addr,
   output wfid_t             o_mem_rd_tag,
   input  logic              i_mem_ack,
   input  wfid_t             i_mem_ack_tag,
   input  pc_t               i_mem_rd_data,
   output logic              o_fetch_reserve_valid,
   output wfid_t             o_fetch_reserve_slotid,
   output logic              o_buff2fetchwave_ack,
   output logic [TAG_W-1:0]  o_buff_tag,
   output pc_t               o_buff_instr
);
   logic [NUM_WF-1:0] r_active;
   logic [NUM_WF-1:0] r_pending;
   logic [NUM_WF-1:0] r_stale;
   logic [NUM_WF-1:0] r_first;
   pc_t               r_pc    [NUM_WF];
   pc_t               r_reqpc [NUM_WF];
   wfid_t             r_ptr;

   logic [NUM_WF-1:0] w_eligible;
   wfid_t             w_grant;
   logic              w_grant_valid;
   logic              w_issue;
   logic              w_br_taken;
   logic              w_resp_kill;
   logic              w_deliver;
   logic              w_br_stale;

   assign w_eligible = r_active & ~r_pending & ~i_fetch_stop_fetch;
   assign w_issue    = w_grant_valid & i_mem_rd_ready;
   assign w_br_taken = i_salu_branch_en & i_salu_branch_taken;

   // Any same-cycle redirect, completion or redispatch of the responding slot invalidates the word.
   assign w_resp_kill = (w_br_taken && (i_salu_branch_wfid == i_mem_ack_tag))
                     || (i_issue_wf_done_en && (i_issue_wf_done_wf_id == i_mem_ack_tag))
                     || (i_dispatch_valid && (i_dispatch_wfid == i_mem_ack_tag));
   assign w_deliver = i_mem_ack & r_active[i_mem_ack_tag] & ~r_stale[i_mem_ack_tag] & ~w_resp_kill;

   // A taken branch poisons whatever request remains in flight for that slot after this edge.
   assign w_br_stale = (r_pending[i_salu_branch_wfid]
                        && !(i_mem_ack && (i_mem_ack_tag == i_salu_branch_wfid)))
                    || (w_issue && (w_grant == i_salu_branch_wfid));

   fetch_rr_arbiter u_arb (
      .i_eligible    (w_eligible),
      .i_ptr         (r_ptr),
      .o_grant_id    (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active               <= '0;
         r_pending              <= '0;
         r_stale                <= '0;
         r_first                <= '0;
         r_ptr                  <= '0;
         for (int i = 0; i < NUM_WF; i++) begin
            r_pc[i]    <= '0;
            r_reqpc[i] <= '0;
         end
         o_fetch_basereg_wr     <= 1'b0;
         o_fetch_basereg_wfid   <= '0;
         o_fetch_vgpr_base      <= '0;
         o_fetch_sgpr_base      <= '0;
         o_fetch_lds_base       <= '0;
         o_mem_rd_en            <= 1'b0;
         o_mem_rd_addr          <= '0;
         o_mem_rd_tag           <= '0;
         o_fetch_reserve_valid  <= 1'b0;
         o_fetch_reserve_slotid <= '0;
         o_buff2fetchwave_ack   <= 1'b0;
         o_buff_tag             <= '0;
         o_buff_instr           <= '0;
      end else begin
         o_mem_rd_en           <= w_issue;
         o_fetch_reserve_valid <= w_issue;
         o_buff2fetchwave_ack  <= w_deliver;
         o_fetch_basereg_wr    <= i_dispatch_valid;

         if (w_issue) begin
            o_mem_rd_addr          <= r_pc[w_grant];
            o_mem_rd_tag           <= w_grant;
            o_fetch_reserve_slotid <= w_grant;
            r_pending[w_grant]     <= 1'b1;
            r_reqpc[w_grant]       <= r_pc[w_grant];
            r_pc[w_grant]          <= r_pc[w_grant] + PC_W'(PC_INCR);
            r_ptr                  <= wfid_wrap_add(w_grant, WFID_W'(1));
         end

         if (i_mem_ack) begin
            r_pending[i_mem_ack_tag] <= 1'b0;
            r_stale[i_mem_ack_tag]   <= 1'b0;
            if (w_deliver) begin
               o_buff_tag[FIRST_BIT]         <= r_first[i_mem_ack_tag];
               o_buff_tag[WFID_MSB:WFID_LSB] <= i_mem_ack_tag;
               o_buff_tag[PC_W-1:0]          <= r_reqpc[i_mem_ack_tag];
               o_buff_instr                  <= i_mem_rd_data;
               r_first[i_mem_ack_tag]        <= 1'b0;
            end
         end

         // Later updates override earlier ones: branch beats issue, dispatch beats everything.
         if (w_br_taken) begin
            r_pc[i_salu_branch_wfid] <= i_salu_branch_target;
            if (w_br_stale) r_stale[i_salu_branch_wfid] <= 1'b1;
         end

         if (i_issue_wf_done_en) r_active[i_issue_wf_done_wf_id] <= 1'b0;

         if (i_dispatch_valid) begin
            r_pc[i_dispatch_wfid]      <= i_dispatch_pc;
            r_active[i_dispatch_wfid]  <= 1'b1;
            r_first[i_dispatch_wfid]   <= 1'b1;
            r_pending[i_dispatch_wfid] <= 1'b0;
            r_stale[i_dispatch_wfid]   <= 1'b0;
            o_fetch_basereg_wfid       <= i_dispatch_wfid;
            o_fetch_vgpr_base          <= i_dispatch_vgpr_base;
            o_fetch_sgpr_base          <= i_dispatch_sgpr_base;
            o_fetch_lds_base           <= i_dispatch_lds_base;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fetch_wave_streamer.sv
`default_nettype none
// tb_fetch_wave_streamer: directed and random stimulus against a slot-level reference model.
// Rev 1.0
module tb_fetch_wave_streamer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        dispatch_valid;
   logic [5:0]  dispatch_wfid;
   logic [31:0] dispatch_pc;
   logic [9:0]  dispatch_vgpr_base;
   logic [8:0]  dispatch_sgpr_base;
   logic [15:0] dispatch_lds_base;
   logic        fetch_basereg_wr;
   logic [5:0]  fetch_basereg_wfid;
   logic [9:0]  fetch_vgpr_base;
   logic [8:0]  fetch_sgpr_base;
   logic [15:0] fetch_lds_base;
   logic [39:0] fetch_stop_fetch;
   logic        done_en;
   logic [5:0]  done_id;
   logic        br_en;
   logic [5:0]  br_wfid;
   logic        br_taken;
   logic [31:0] br_target;
   logic        mem_rd_ready;
   logic        mem_rd_en;
   logic [31:0] mem_rd_addr;
   logic [5:0]  mem_rd_tag;
   logic        mem_ack;
   logic [5:0]  mem_ack_tag;
   logic [31:0] mem_rd_data;
   logic        reserve_valid;
   logic [5:0]  reserve_slotid;
   logic        buff_ack;
   logic [38:0] buff_tag;
   logic [31:0] buff_instr;

   always #5 clk = ~clk;

   fetch_wave_streamer dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .i_dispatch_valid       (dispatch_valid),
      .i_dispatch_wfid        (dispatch_wfid),
      .i_dispatch_pc          (dispatch_pc),
      .i_dispatch_vgpr_base   (dispatch_vgpr_base),
      .i_dispatch_sgpr_base   (dispatch_sgpr_base),
      .i_dispatch_lds_base    (dispatch_lds_base),
      .o_fetch_basereg_wr     (fetch_basereg_wr),
      .o_fetch_basereg_wfid   (fetch_basereg_wfid),
      .o_fetch_vgpr_base      (fetch_vgpr_base),
      .o_fetch_sgpr_base      (fetch_sgpr_base),
      .o_fetch_lds_base       (fetch_lds_base),
      .i_fetch_stop_fetch     (fetch_stop_fetch),
      .i_issue_wf_done_en     (done_en),
      .i_issue_wf_done_wf_id  (done_id),
      .i_salu_branch_en       (br_en),
      .i_salu_branch_wfid     (br_wfid),
      .i_salu_branch_taken    (br_taken),
      .i_salu_branch_target   (br_target),
      .i_mem_rd_ready         (mem_rd_ready),
      .o_mem_rd_en            (mem_rd_en),
      .o_mem_rd_addr          (mem_rd_addr),
      .o_mem_rd_tag           (mem_rd_tag),
      .i_mem_ack              (mem_ack),
      .i_mem_ack_tag          (mem_ack_tag),
      .i_mem_rd_data          (mem_rd_data),
      .o_fetch_reserve_valid  (reserve_valid),
      .o_fetch_reserve_slotid (reserve_slotid),
      .o_buff2fetchwave_ack   (buff_ack),
      .o_buff_tag             (buff_tag),
      .o_buff_instr           (buff_instr)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: architectural per-slot state.
   logic [31:0] m_pc    [40];
   logic [31:0] m_reqpc [40];
   bit          m_act   [40];
   bit          m_pend  [40];
   bit          m_stale [40];
   bit          m_first [40];
   int          m_ptr;

   bit          e_rd_en, e_ack, e_bwr;
   logic [31:0] e_addr, e_instr;
   logic [5:0]  e_rtag, e_bwfid;
   logic [38:0] e_tag;
   logic [9:0]  e_vb;
   logic [8:0]  e_sb;
   logic [15:0] e_lb;

   typedef struct { int tag; logic [31:0] addr; int due; } req_t;
   req_t memq[$];
   int   lat_min = 0;
   int   lat_max = 0;

   int          log_tag[$];
   logic [31:0] log_addr[$];
   logic [38:0] log_btag[$];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic int count_req(input int t);
      int n = 0;
      foreach (log_tag[i]) if (log_tag[i] == t) n++;
      return n;
   endfunction

   function automatic logic [31:0] first_req_addr(input int t);
      foreach (log_tag[i]) if (log_tag[i] == t) return log_addr[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic int count_ack(input int t);
      int n = 0;
      foreach (log_btag[i]) if (int'(log_btag[i][37:32]) == t) n++;
      return n;
   endfunction

   function automatic logic [38:0] first_ack(input int t);
      foreach (log_btag[i]) if (int'(log_btag[i][37:32]) == t) return log_btag[i];
      return '0;
   endfunction

   task automatic clear_logs();
      log_tag.delete(); log_addr.delete(); log_btag.delete();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 40; i++) begin
         m_pc[i] = '0; m_reqpc[i] = '0;
         m_act[i] = 0; m_pend[i] = 0; m_stale[i] = 0; m_first[i] = 0;
      end
      m_ptr = 0;
   endtask

   // Predicts the registered outputs produced by the coming edge, then advances the model.
   task automatic model_cycle();
      int  pick, t, bw;
      bit  found, kill, br, bw_pend;
      found = 0; pick = 0;
      if (mem_rd_ready) begin
         for (int k = 0; k < 40; k++) begin
            int i;
            i = (m_ptr + k) % 40;
            if (m_act[i] && !m_pend[i] && !fetch_stop_fetch[i]) begin
               pick = i; found = 1; break;
            end
         end
      end
      t  = int'(mem_ack_tag);
      bw = int'(br_wfid);
      br = br_en && br_taken;
      bw_pend = m_pend[bw];
      kill = (br && br_wfid == mem_ack_tag) || (done_en && done_id == mem_ack_tag)
          || (dispatch_valid && dispatch_wfid == mem_ack_tag);

      e_rd_en = found;
      if (found) begin e_addr = m_pc[pick]; e_rtag = 6'(pick); end
      e_ack = mem_ack && m_act[t] && !m_stale[t] && !kill;
      if (e_ack) begin e_tag = {m_first[t], mem_ack_tag, m_reqpc[t]}; e_instr = mem_rd_data; end
      e_bwr = dispatch_valid;
      if (dispatch_valid) begin
         e_bwfid = dispatch_wfid; e_vb = dispatch_vgpr_base;
         e_sb = dispatch_sgpr_base; e_lb = dispatch_lds_base;
      end

      if (found) begin
         m_pend[pick] = 1; m_reqpc[pick] = m_pc[pick];
         m_pc[pick] = m_pc[pick] + 32'd4; m_ptr = (pick + 1) % 40;
      end
      if (mem_ack) begin
         m_pend[t] = 0; m_stale[t] = 0;
         if (e_ack) m_first[t] = 0;
      end
      if (br) begin
         m_pc[bw] = br_target;
         if ((found && pick == bw) || (bw_pend && !(mem_ack && t == bw))) m_stale[bw] = 1;
      end
      if (done_en) m_act[int'(done_id)] = 0;
      if (dispatch_valid) begin
         int d;
         d = int'(dispatch_wfid);
         m_pc[d] = dispatch_pc; m_act[d] = 1; m_first[d] = 1; m_pend[d] = 0; m_stale[d] = 0;
      end
   endtask

   task automatic check_outputs();
      chk("rd_en", 64'(mem_rd_en), 64'(e_rd_en));
      chk("reserve_valid", 64'(reserve_valid), 64'(e_rd_en));
      if (e_rd_en) begin
         chk("rd_addr", 64'(mem_rd_addr), 64'(e_addr));
         chk("rd_tag", 64'(mem_rd_tag), 64'(e_rtag));
         chk("reserve_slot", 64'(reserve_slotid), 64'(e_rtag));
      end
      chk("buff_ack", 64'(buff_ack), 64'(e_ack));
      if (e_ack) begin
         chk("buff_tag", 64'(buff_tag), 64'(e_tag));
         chk("buff_instr", 64'(buff_instr), 64'(e_instr));
      end
      chk("basereg_wr", 64'(fetch_basereg_wr), 64'(e_bwr));
      if (e_bwr) begin
         chk("basereg_wfid", 64'(fetch_basereg_wfid), 64'(e_bwfid));
         chk("bases", 64'({fetch_vgpr_base, fetch_sgpr_base, fetch_lds_base}),
             64'({e_vb, e_sb, e_lb}));
      end
   endtask

   // One clock: predict, take the edge, compare, then act as instruction memory.
   task automatic step();
      req_t r;
      model_cycle();
      @(posedge clk); #1;
      check_outputs();
      if (mem_rd_en) begin log_tag.push_back(int'(mem_rd_tag)); log_addr.push_back(mem_rd_addr); end
      if (buff_ack) log_btag.push_back(buff_tag);
      cyc++;
      if (e_rd_en) begin
         r.tag = int'(e_rtag); r.addr = e_addr;
         r.due = cyc + int'($urandom_range(lat_max, lat_min));
         memq.push_back(r);
      end
      dispatch_valid = 0; done_en = 0; br_en = 0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         r = memq.pop_front();
         mem_ack = 1; mem_ack_tag = 6'(r.tag); mem_rd_data = instr_of(r.addr);
      end else begin
         mem_ack = 0; mem_ack_tag = 6'($urandom_range(39, 0)); mem_rd_data = $urandom;
      end
   endtask

   task automatic disp(input int w, input logic [31:0] pc);
      dispatch_valid = 1; dispatch_wfid = 6'(w); dispatch_pc = pc;
      dispatch_vgpr_base = 10'($urandom); dispatch_sgpr_base = 9'($urandom);
      dispatch_lds_base = 16'($urandom);
   endtask

   task automatic wait_pend(input int s);
      int n = 0;
      while (!m_pend[s] && n < 40) begin step(); n++; end
      chk("wait_pending", 64'(m_pend[s]), 64'd1);
   endtask

   // Asserts reset between edges and checks that every output clears without a clock.
   task automatic do_reset_async();
      #2; rst_n = 0; #1;
      chk("rst_strobes", 64'({mem_rd_en, reserve_valid, buff_ack, fetch_basereg_wr}), 64'd0);
      chk("rst_rd", 64'({mem_rd_addr, mem_rd_tag, reserve_slotid}), 64'd0);
      chk("rst_buff", 64'(buff_tag), 64'd0);
      chk("rst_instr", 64'(buff_instr), 64'd0);
      chk("rst_base", 64'({fetch_basereg_wfid, fetch_vgpr_base, fetch_sgpr_base, fetch_lds_base}), 64'd0);
      model_reset(); memq.delete();
      dispatch_valid = 0; done_en = 0; br_en = 0; br_taken = 0; mem_ack = 0; fetch_stop_fetch = '0;
      @(negedge clk); rst_n = 1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1; dispatch_valid = 0; dispatch_wfid = 0; dispatch_pc = 0;
      dispatch_vgpr_base = 0; dispatch_sgpr_base = 0; dispatch_lds_base = 0;
      fetch_stop_fetch = '0; done_en = 0; done_id = 0; br_en = 0; br_wfid = 0; br_taken = 0;
      br_target = 0; mem_rd_ready = 1; mem_ack = 0; mem_ack_tag = 0; mem_rd_data = 0;
      model_reset();
      @(posedge clk); #1;
      do_reset_async();

      // Single wavefront, 1-cycle memory: sequential PCs, first flag only on the first delivery.
      disp(3, 32'h100); step();
      clear_logs();
      repeat (8) step();
      chk("wf3_nreq", 64'(log_tag.size()), 64'd4);
      chk("wf3_addr0", 64'(first_req_addr(3)), 64'h100);
      chk("wf3_addr1", 64'(log_addr.size() > 1 ? log_addr[1] : 32'h0), 64'h104);
      chk("wf3_addr2", 64'(log_addr.size() > 2 ? log_addr[2] : 32'h0), 64'h108);
      chk("wf3_first_ack", 64'(first_ack(3)), 64'({1'b1, 6'd3, 32'h100}));
      chk("wf3_second_first", 64'(log_btag.size() > 1 ? log_btag[1][38] : 1'b1), 64'd0);

      // Rotation 0 -> 1 -> 39 -> 0 from a cleared pointer.
      do_reset_async();
      mem_rd_ready = 0;
      disp(0, 32'h1000); step();
      disp(1, 32'h2000); step();
      disp(39, 32'h3000); step();
      mem_rd_ready = 1; clear_logs();
      repeat (4) step();
      chk("rot_n", 64'(log_tag.size()), 64'd4);
      for (int i = 0; i < 4 && i < log_tag.size(); i++) begin
         int exp_t;
         exp_t = (i == 2) ? 39 : (i == 1 ? 1 : 0);
         chk("rot_grant", 64'(log_tag[i]), 64'(exp_t));
      end

      // Back-pressure on slot 1.
      fetch_stop_fetch = 40'h2; clear_logs();
      repeat (12) step();
      chk("stop_wf1_none", 64'(count_req(1)), 64'd0);
      chk("stop_others_run", 64'(count_req(0) > 0), 64'd1);
      fetch_stop_fetch = '0; clear_logs();
      repeat (6) step();
      chk("stop_wf1_resume", 64'(count_req(1) > 0), 64'd1);

      // Taken branch while a request is in flight.
      lat_min = 2; lat_max = 2;
      disp(2, 32'h200); step();
      wait_pend(2);
      br_en = 1; br_taken = 1; br_wfid = 6'd2; br_target = 32'h400;
      clear_logs(); step();
      repeat (12) step();
      chk("br_first_req", 64'(first_req_addr(2)), 64'h400);
      chk("br_first_ack", 64'(first_ack(2)), 64'({1'b1, 6'd2, 32'h400}));

      // Completion while a request is in flight, then redispatch.
      disp(5, 32'h500); step();
      wait_pend(5);
      done_en = 1; done_id = 6'd5;
      clear_logs(); step();
      repeat (12) step();
      chk("done_no_ack", 64'(count_ack(5)), 64'd0);
      chk("done_no_req", 64'(count_req(5)), 64'd0);
      disp(5, 32'h580); step();
      clear_logs();
      repeat (10) step();
      chk("redisp_addr", 64'(first_req_addr(5)), 64'h580);

      // Random traffic.
      lat_min = 0; lat_max = 4;
      repeat (400) begin
         mem_rd_ready = ($urandom_range(3, 0) != 0);
         fetch_stop_fetch = 40'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
         if ($urandom_range(7, 0) == 0) disp(int'($urandom_range(39, 0)), 32'($urandom) & 32'hFFFF_FFFC);
         if ($urandom_range(15, 0) == 0) begin done_en = 1; done_id = 6'($urandom_range(39, 0)); end
         if ($urandom_range(9, 0) == 0) begin
            br_en = 1; br_taken = 1; br_wfid = 6'($urandom_range(39, 0));
            br_target = 32'($urandom) & 32'hFFFF_FFFC;
         end
         step();
      end

      // Reset in the middle of traffic, then silence until a dispatch.
      mem_rd_ready = 1;
      do_reset_async();
      clear_logs();
      repeat (10) step();
      chk("post_rst_idle", 64'(log_tag.size()), 64'd0);
      disp(7, 32'h700); step();
      repeat (4) step();
      chk("post_rst_disp", 64'(first_req_addr(7)), 64'h700);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
